// File: rtl/test_monitor.sv
// rtl/test_monitor.sv - pass/fail/timeout monitor snooping core register writeback
// Optional watchdog enabled by defining TEST_MONITOR_TIMEOUT_EN.
module test_monitor #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] fail_testnum,
  output logic [31:0] cycle_count
);

  typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL, ST_TIMEOUT} state_t;

  state_t      state_q, state_d;
  logic [31:0] sh_x3_q, sh_x3_d;
  logic [31:0] sh_x27_q, sh_x27_d;
  logic [31:0] cycle_count_q, cycle_count_d;
  logic [31:0] fail_testnum_q, fail_testnum_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        timeout_q, timeout_d;
  logic        in_run;
  logic        done_event;
  logic        timeout_event;

  assign in_run     = (state_q == ST_RUN);
  assign done_event = in_run && wb_en && (wb_addr == 5'd26) && (wb_data == 32'd1);

`ifdef TEST_MONITOR_TIMEOUT_EN
  localparam logic [31:0] LAST_CYCLE = TIMEOUT_CYCLES - 32'd1;
  assign timeout_event = in_run && (cycle_count_q == LAST_CYCLE);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_event      = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    sh_x3_d        = sh_x3_q;
    sh_x27_d       = sh_x27_q;
    cycle_count_d  = cycle_count_q;
    fail_testnum_d = fail_testnum_q;
    done_d         = done_q;
    pass_d         = pass_q;
    timeout_d      = timeout_q;
    if (in_run) begin
      if (wb_en && (wb_addr == 5'd3))  sh_x3_d  = wb_data;
      if (wb_en && (wb_addr == 5'd27)) sh_x27_d = wb_data;
      // Done wins over the watchdog; the count is not advanced on the exit cycle.
      if (done_event) begin
        done_d = 1'b1;
        if (sh_x27_q == 32'd1) begin
          state_d = ST_PASS;
          pass_d  = 1'b1;
        end else begin
          state_d        = ST_FAIL;
          fail_testnum_d = sh_x3_q;
        end
      end else if (timeout_event) begin
        state_d        = ST_TIMEOUT;
        done_d         = 1'b1;
        timeout_d      = 1'b1;
        fail_testnum_d = sh_x3_q;
      end else if (cycle_count_q != 32'hFFFF_FFFF) begin
        cycle_count_d = cycle_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      sh_x3_q        <= 32'd0;
      sh_x27_q       <= 32'd0;
      cycle_count_q  <= 32'd0;
      fail_testnum_q <= 32'd0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      sh_x3_q        <= sh_x3_d;
      sh_x27_q       <= sh_x27_d;
      cycle_count_q  <= cycle_count_d;
      fail_testnum_q <= fail_testnum_d;
      done_q         <= done_d;
      pass_q         <= pass_d;
      timeout_q      <= timeout_d;
    end
  end

  assign done         = done_q;
  assign pass         = pass_q;
  assign timeout      = timeout_q;
  assign fail_testnum = fail_testnum_q;
  assign cycle_count  = cycle_count_q;

endmodule

// File: tb/tb_test_monitor.sv
// tb/tb_test_monitor.sv - randomized + directed check of test_monitor against a behavioural model
module tb_test_monitor;

  localparam logic [31:0] TC = 32'd10;
`ifdef TEST_MONITOR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic        done, pass, timeout;
  logic [31:0] fail_testnum, cycle_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model: "finished" flag plus outcome flags, shadow values and counters.
  bit          m_done, m_pass, m_to;
  logic [31:0] m_x3, m_x27, m_cnt, m_ftn;

  test_monitor #(.TIMEOUT_CYCLES(TC)) dut (
    .clk(clk), .rst(rst), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .done(done), .pass(pass), .timeout(timeout),
    .fail_testnum(fail_testnum), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic model_step(input bit r, input bit e, input logic [4:0] a, input logic [31:0] d);
    bit finish_ok, watchdog;
    if (r) begin
      m_done = 0; m_pass = 0; m_to = 0;
      m_x3 = 0; m_x27 = 0; m_cnt = 0; m_ftn = 0;
    end else if (!m_done) begin
      finish_ok = e && (a == 5'd26) && (d == 32'd1);
      watchdog  = TO_EN && (m_cnt == TC - 1);
      if (finish_ok) begin
        m_done = 1;
        m_pass = (m_x27 == 32'd1);
        if (!m_pass) m_ftn = m_x3;
      end else if (watchdog) begin
        m_done = 1; m_to = 1; m_ftn = m_x3;
      end else if (m_cnt != 32'hFFFF_FFFF) begin
        m_cnt = m_cnt + 1;
      end
      if (e && a == 5'd3)  m_x3  = d;
      if (e && a == 5'd27) m_x27 = d;
    end
  endtask

  task automatic step(input bit r, input bit e, input logic [4:0] a, input logic [31:0] d);
    rst = r; wb_en = e; wb_addr = a; wb_data = d;
    @(posedge clk);
    model_step(r, e, a, d);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 5'd0, 32'd0);
  endtask

  task automatic lit(input string name, input logic [31:0] dut_v, input logic [31:0] mdl_v,
                     input logic [31:0] exp_v);
    n_checks++;
    if (dut_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: dut=%0d expected=%0d", name, dut_v, exp_v);
    end
    n_checks++;
    if (mdl_v !== exp_v) begin
      n_fail++;
      $display("FAIL model_%s: model=%0d expected=%0d", name, mdl_v, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if ({done, pass, timeout, fail_testnum, cycle_count} !==
          {m_done, m_pass, m_to, m_ftn, m_cnt}) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t: dut done=%0b pass=%0b to=%0b ftn=%0d cnt=%0d model done=%0b pass=%0b to=%0b ftn=%0d cnt=%0d",
                 $time, done, pass, timeout, fail_testnum, cycle_count,
                 m_done, m_pass, m_to, m_ftn, m_cnt);
      end
    end
  end

  function automatic logic [4:0] rand_addr();
    case ($urandom_range(0, 5))
      0: return 5'd0;
      1: return 5'd3;
      2: return 5'd26;
      3: return 5'd27;
      default: return 5'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] rand_data();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1, 2: return 32'd1;
      3: return 32'd2;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    step(1, 0, 5'd0, 32'd0);
    chk_en = 1'b1;
    lit("reset_done", {31'd0, done}, {31'd0, m_done}, 32'd0);
    lit("reset_cnt", cycle_count, m_cnt, 32'd0);
    lit("reset_ftn", fail_testnum, m_ftn, 32'd0);

    // x27=1 then x26=1 -> PASS
    step(0, 1, 5'd27, 32'd1);
    lit("pass_pre_done", {31'd0, done}, {31'd0, m_done}, 32'd0);
    step(0, 1, 5'd26, 32'd1);
    lit("pass_done", {31'd0, done}, {31'd0, m_done}, 32'd1);
    lit("pass_pass", {31'd0, pass}, {31'd0, m_pass}, 32'd1);
    lit("pass_ftn", fail_testnum, m_ftn, 32'd0);
    lit("pass_cnt", cycle_count, m_cnt, 32'd1);

    // reset pulse in PASS with traffic that must be ignored
    step(1, 1, 5'd27, 32'd1);
    lit("rst_done", {31'd0, done}, {31'd0, m_done}, 32'd0);
    lit("rst_pass", {31'd0, pass}, {31'd0, m_pass}, 32'd0);
    lit("rst_cnt", cycle_count, m_cnt, 32'd0);
    step(0, 1, 5'd26, 32'd2);
    lit("x26_2_done", {31'd0, done}, {31'd0, m_done}, 32'd0);
    lit("x26_2_cnt", cycle_count, m_cnt, 32'd1);
    step(0, 1, 5'd26, 32'd1);
    lit("rst_x27_ignored_pass", {31'd0, pass}, {31'd0, m_pass}, 32'd0);
    lit("rst_x27_ignored_done", {31'd0, done}, {31'd0, m_done}, 32'd1);

    // x3=5, x27=0, x26=1 -> FAIL with testnum 5, frozen afterwards
    step(1, 0, 5'd0, 32'd0);
    step(0, 1, 5'd3, 32'd5);
    step(0, 1, 5'd27, 32'd0);
    step(0, 1, 5'd26, 32'd1);
    lit("fail_done", {31'd0, done}, {31'd0, m_done}, 32'd1);
    lit("fail_pass", {31'd0, pass}, {31'd0, m_pass}, 32'd0);
    lit("fail_to", {31'd0, timeout}, {31'd0, m_to}, 32'd0);
    lit("fail_ftn", fail_testnum, m_ftn, 32'd5);
    step(0, 1, 5'd27, 32'd1);
    step(0, 1, 5'd3, 32'd9);
    lit("fail_frozen_pass", {31'd0, pass}, {31'd0, m_pass}, 32'd0);
    lit("fail_frozen_ftn", fail_testnum, m_ftn, 32'd5);

`ifdef TEST_MONITOR_TIMEOUT_EN
    // watchdog: x3=7, no finish write
    step(1, 0, 5'd0, 32'd0);
    step(0, 1, 5'd3, 32'd7);
    idle(8);
    lit("to_pre_done", {31'd0, done}, {31'd0, m_done}, 32'd0);
    lit("to_pre_cnt", cycle_count, m_cnt, 32'd9);
    idle(1);
    lit("to_timeout", {31'd0, timeout}, {31'd0, m_to}, 32'd1);
    lit("to_done", {31'd0, done}, {31'd0, m_done}, 32'd1);
    lit("to_ftn", fail_testnum, m_ftn, 32'd7);
    idle(3);
    lit("to_cnt_frozen", cycle_count, m_cnt, 32'd9);

    // finish write in the last allowed cycle wins over the watchdog
    step(1, 0, 5'd0, 32'd0);
    step(0, 1, 5'd27, 32'd1);
    idle(8);
    lit("edge_cnt", cycle_count, m_cnt, 32'd9);
    step(0, 1, 5'd26, 32'd1);
    lit("edge_pass", {31'd0, pass}, {31'd0, m_pass}, 32'd1);
    lit("edge_to", {31'd0, timeout}, {31'd0, m_to}, 32'd0);
`else
    // no watchdog: keeps running
    step(1, 0, 5'd0, 32'd0);
    idle(50);
    lit("nowd_to", {31'd0, timeout}, {31'd0, m_to}, 32'd0);
    lit("nowd_done", {31'd0, done}, {31'd0, m_done}, 32'd0);
    lit("nowd_cnt", cycle_count, m_cnt, 32'd50);
`endif

    // randomized runs, compared every cycle by the compare process
    for (int run = 0; run < 40; run++) begin
      step(1, 1'($urandom), rand_addr(), rand_data());
      for (int c = 0; c < int'($urandom_range(3, 30)); c++) begin
        step(($urandom_range(0, 40) == 0), ($urandom_range(0, 2) != 0), rand_addr(), rand_data());
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
